cache_data_ram: RTL and testbench
=================================

Name: cache_data_ram

Overview:
- Parametrised successor to the single-port-per-direction instruction cache line RAM.
- Multi-way, byte-maskable, simple dual-port line storage for the I/D caches.
- Adds a post-reset/flush clear sequencer, write-first read bypass and read-enable hold.
- Sits under the cache controller: the controller reads all ways of a set in parallel and writes refills or stores into selected ways.

Parameters:
WIDTH, 512, line width in bits per way; must be a multiple of 8
ADDR_BITS, 9, set index width; depth = 2**ADDR_BITS sets
WAYS, 2, number of ways read in parallel; must be >= 1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  start/restart the clear sequence
init_busy_o  out  1  clear sequence in progress; all requests ignored
rd_en_i  in  1  read request
rd_addr_i  in  ADDR_BITS  read set index
rd_data_o  out  WAYS*WIDTH  way w occupies bits [w*WIDTH +: WIDTH]
rd_valid_o  out  1  rd_data_o carries fresh read data this cycle
wr_addr_i  in  ADDR_BITS  write set index
wr_way_i  in  WAYS  per-way write enable mask; multiple bits allowed
wr_be_i  in  WIDTH/8  byte enables, bit b covers data bits [8b+7:8b]
wr_data_i  in  WIDTH  write data, replicated to every enabled way

Behaviour:
- Reset (rst_n low, async):
  - rd_data_o=0, rd_valid_o=0, init_busy_o=1.
  - FSM=INIT, clear counter=0.
  - Array contents are not reset directly.
- FSM states INIT and READY:
  - INIT:
    - Each cycle writes all-zero to every way at index = counter, then counter increments.
    - After writing index 2**ADDR_BITS-1, go to READY next cycle.
    - INIT takes exactly 2**ADDR_BITS cycles after rst_n deasserts.
    - flush_i in INIT restarts counter at 0.
  - READY: init_busy_o=0. flush_i=1 moves to INIT with counter=0 and init_busy_o=1 from the next cycle.
- While init_busy_o=1:
  - rd_en_i and wr_way_i are ignored; user writes are dropped.
  - rd_valid_o=0 and rd_data_o holds its value.
- A flush_i sampled in READY in the same cycle as a read or write still services that request. The clear then overwrites the array.
- Read path (READY):
  - rd_en_i sampled at edge T → rd_data_o and rd_valid_o=1 valid after edge T+1.
  - Latency is 1 cycle; rd_valid_o is a single-cycle pulse per request.
  - Back-to-back reads give one result per cycle.
  - rd_en_i=0: rd_valid_o=0 and rd_data_o holds the last read value (stall hold).
- Write path (READY): for each way w with wr_way_i[w]=1, byte b is updated iff wr_be_i[b]=1. wr_way_i=0 or wr_be_i=0 leaves the array unchanged.
- Read-during-write, same address, same edge: write-first. Per way and byte, the returned byte is new data where that way and byte are written, otherwise the old array byte.
- Different read and write addresses have no interaction.
- Write and read each accept one request per cycle, independent of each other.

Optional Feature:
- Macro: CACHE_DATA_RAM_OUT_REG_EN.
- Defined:
  - Adds an output register stage; read latency becomes 2 cycles.
  - rd_valid_o is delayed with the data; the stall hold applies at the output stage.
  - Bypass still reflects a write at the same edge as the read request.
  - flush_i or reset clears the pipeline valid bit; output data resets to 0.
- Undefined: 1-cycle latency as described above.

Test Plan:
1. Release rst_n, idle → init_busy_o=1 for exactly 512 cycles, then 0. Read addr 0x1FF → rd_data_o=0, rd_valid_o=1 one cycle later.
2. Write addr 0x005, wr_way_i=2'b10, wr_be_i all ones, data A5 repeated. Read 0x005 next cycle → way1=A5 pattern, way0=0.
3. Write addr 0x010 all-FF to both ways. Then write 0x010 with wr_be_i=only byte 0, data 0x00. Read → each way byte0=00, other bytes FF.
4. Same-edge write 0x020 (way0, byte 3=0x5C) and read 0x020 → rd_data_o way0 byte3=5C, old bytes elsewhere, way1 old value.
5. Read 0x005, then hold rd_en_i=0 for 3 cycles → rd_valid_o pulses once, rd_data_o stays constant. Then pulse flush_i → init_busy_o=1 for 512 cycles, a read issued mid-flush gives no rd_valid_o, and all locations read 0 after.
6. Assert rst_n low during INIT at counter 100 → outputs reset immediately; after release the full 512-cycle clear reruns.

Source files
------------

// File: rtl/cache_data_ram.sv
// Multi-way, byte-maskable simple dual-port cache line RAM with a post-reset/flush
// clear sequencer and write-first read bypass. Define CACHE_DATA_RAM_OUT_REG_EN for a 2-cycle read.
module cache_data_ram #(
  parameter int WIDTH     = 512,
  parameter int ADDR_BITS = 9,
  parameter int WAYS      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  output logic                    init_busy_o,
  input  logic                    rd_en_i,
  input  logic [ADDR_BITS-1:0]    rd_addr_i,
  output logic [WAYS*WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o,
  input  logic [ADDR_BITS-1:0]    wr_addr_i,
  input  logic [WAYS-1:0]         wr_way_i,
  input  logic [WIDTH/8-1:0]      wr_be_i,
  input  logic [WIDTH-1:0]        wr_data_i
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int BYTES = WIDTH / 8;
  localparam logic [ADDR_BITS-1:0] CNT_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] CNT_LAST = {ADDR_BITS{1'b1}};

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
  logic                   busy_q;
  logic [WAYS*WIDTH-1:0]  rd_data_q;
  logic                   rd_valid_q;
  logic [WAYS*WIDTH-1:0]  rd_merge_s;
  logic                   ready_s;
  logic                   wr_hit_s;
  logic [WIDTH-1:0]       mem_q [WAYS][DEPTH];

  assign ready_s  = (state_q == ST_READY);
  assign wr_hit_s = ready_s && (wr_addr_i == rd_addr_i);

  // Clear sequencer next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_READY: begin
        if (flush_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state, counter and busy flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_INIT);
    end
  end

  // Write-first merge: per way and byte, same-edge written bytes override the array
  always_comb begin
    rd_merge_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_hit_s && wr_way_i[w] && wr_be_i[b]) begin
          rd_merge_s[w*WIDTH + b*8 +: 8] = wr_data_i[b*8 +: 8];
        end else begin
          rd_merge_s[w*WIDTH + b*8 +: 8] = mem_q[w][rd_addr_i][b*8 +: 8];
        end
      end
    end
  end

  // Array update: whole-line zeroing while clearing, byte-masked user writes when ready
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (!ready_s) begin
        mem_q[w][cnt_q] <= '0;
      end else begin
        for (int b = 0; b < BYTES; b++) begin
          if (wr_way_i[w] && wr_be_i[b]) begin
            mem_q[w][wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read stage: capture on request, otherwise hold data and drop valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (ready_s && rd_en_i) begin
      rd_data_q  <= rd_merge_s;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

`ifdef CACHE_DATA_RAM_OUT_REG_EN
  logic [WAYS*WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  // Output stage: hold applies here; flush kills a result in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (rd_valid_q) begin
      out_data_q  <= rd_data_q;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign rd_data_o  = out_data_q;
  assign rd_valid_o = out_valid_q;
`else
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

  assign init_busy_o = busy_q;

endmodule

// File: tb/tb_cache_data_ram.sv
// Directed bench for cache_data_ram (default build, 2 ways x 512 bits x 512 sets).
module tb_cache_data_ram;

  localparam int W  = 512;
  localparam int AB = 9;
  localparam int WY = 2;

  logic            clk;
  logic            rst_n;
  logic            flush_i;
  logic            init_busy_o;
  logic            rd_en_i;
  logic [AB-1:0]   rd_addr_i;
  logic [WY*W-1:0] rd_data_o;
  logic            rd_valid_o;
  logic [AB-1:0]   wr_addr_i;
  logic [WY-1:0]   wr_way_i;
  logic [W/8-1:0]  wr_be_i;
  logic [W-1:0]    wr_data_i;

  int checks;
  int errors;
  int cycles;
  int seen_valid;
  logic [W-1:0] exp_s;

  cache_data_ram #(.WIDTH(W), .ADDR_BITS(AB), .WAYS(WY)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .init_busy_o(init_busy_o),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .wr_addr_i(wr_addr_i), .wr_way_i(wr_way_i),
    .wr_be_i(wr_be_i), .wr_data_i(wr_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {(W/8){b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    cycles = 0;
    while (init_busy_o && cycles < 2000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [WY-1:0] way,
                    input logic [W/8-1:0] be, input logic [W-1:0] d);
    wr_addr_i = a; wr_way_i = way; wr_be_i = be; wr_data_i = d;
    tick();
    wr_way_i = 2'b00; wr_be_i = '0;
  endtask

  task automatic rd(input logic [AB-1:0] a);
    rd_en_i = 1'b1; rd_addr_i = a;
    tick();
    rd_en_i = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush_i = 1'b0; rd_en_i = 1'b0; rd_addr_i = '0;
    wr_addr_i = '0; wr_way_i = '0; wr_be_i = '0; wr_data_i = '0;
    tick(); tick();
    check_val("rst_busy", W'(init_busy_o), W'(1));
    check_val("rst_valid", W'(rd_valid_o), W'(0));
    check_val("rst_data0", rd_data_o[W-1:0], '0);

    // 1: full clear length, then read last set
    rst_n = 1'b1;
    wait_init();
    check_val("init_len", W'(cycles), W'(512));
    rd(9'h1FF);
    check_val("t1_valid", W'(rd_valid_o), W'(1));
    check_val("t1_way0", rd_data_o[W-1:0], '0);
    check_val("t1_way1", rd_data_o[2*W-1:W], '0);

    // 2: single-way full-line write
    wr(9'h005, 2'b10, {(W/8){1'b1}}, rep(8'hA5));
    rd(9'h005);
    check_val("t2_way1", rd_data_o[2*W-1:W], rep(8'hA5));
    check_val("t2_way0", rd_data_o[W-1:0], '0);

    // 3: byte-masked overwrite in both ways
    wr(9'h010, 2'b11, {(W/8){1'b1}}, rep(8'hFF));
    wr(9'h010, 2'b11, {{(W/8-1){1'b0}}, 1'b1}, '0);
    rd(9'h010);
    exp_s = rep(8'hFF);
    exp_s[7:0] = 8'h00;
    check_val("t3_way0", rd_data_o[W-1:0], exp_s);
    check_val("t3_way1", rd_data_o[2*W-1:W], exp_s);

    // 4: same-edge write/read bypass on one byte of way0
    wr(9'h020, 2'b01, {(W/8){1'b1}}, rep(8'h33));
    wr(9'h020, 2'b10, {(W/8){1'b1}}, rep(8'h77));
    wr_addr_i = 9'h020; wr_way_i = 2'b01; wr_be_i = {{(W/8-4){1'b0}}, 4'b1000};
    wr_data_i = rep(8'hEE);
    wr_data_i[31:24] = 8'h5C;
    rd(9'h020);
    wr_way_i = 2'b00; wr_be_i = '0;
    exp_s = rep(8'h33);
    exp_s[31:24] = 8'h5C;
    check_val("t4_bypass_way0", rd_data_o[W-1:0], exp_s);
    check_val("t4_bypass_way1", rd_data_o[2*W-1:W], rep(8'h77));
    rd(9'h020);
    check_val("t4_stored_way0", rd_data_o[W-1:0], exp_s);

    // 5: stall hold, back-to-back reads, flush
    rd(9'h005);
    check_val("t5_valid", W'(rd_valid_o), W'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t5_hold_valid", W'(rd_valid_o), W'(0));
      check_val("t5_hold_data", rd_data_o[2*W-1:W], rep(8'hA5));
    end
    rd_en_i = 1'b1; rd_addr_i = 9'h010;
    tick();
    check_val("t5_b2b_a", rd_data_o[2*W-1:W], {rep(8'hFF)} & ~W'(8'hFF));
    rd_addr_i = 9'h020;
    tick();
    rd_en_i = 1'b0;
    check_val("t5_b2b_b_valid", W'(rd_valid_o), W'(1));
    check_val("t5_b2b_b", rd_data_o[2*W-1:W], rep(8'h77));
    flush_i = 1'b1; rd_en_i = 1'b1; rd_addr_i = 9'h005;
    tick();
    flush_i = 1'b0; rd_en_i = 1'b0;
    check_val("t5_flush_busy", W'(init_busy_o), W'(1));
    check_val("t5_flush_rd", rd_data_o[2*W-1:W], rep(8'hA5));
    cycles = 0; seen_valid = 0;
    while (init_busy_o && cycles < 2000) begin
      rd_en_i = (cycles == 200);
      rd_addr_i = 9'h005;
      tick();
      cycles++;
      if (rd_valid_o) seen_valid++;
    end
    rd_en_i = 1'b0;
    check_val("t5_flush_len", W'(cycles), W'(512));
    check_val("t5_no_valid", W'(seen_valid), W'(0));
    rd(9'h005);
    check_val("t5_clr_005", rd_data_o[2*W-1:W], '0);
    rd(9'h010);
    check_val("t5_clr_010", rd_data_o[W-1:0], '0);
    rd(9'h020);
    check_val("t5_clr_020", rd_data_o[W-1:0], '0);

    // 6: reset during clear at counter 100
    wr(9'h040, 2'b11, {(W/8){1'b1}}, rep(8'hC3));
    rd(9'h040);
    check_val("t6_pre", rd_data_o[W-1:0], rep(8'hC3));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check_val("t6_hold_in_init", rd_data_o[W-1:0], rep(8'hC3));
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_busy", W'(init_busy_o), W'(1));
    check_val("t6_rst_valid", W'(rd_valid_o), W'(0));
    check_val("t6_rst_way0", rd_data_o[W-1:0], '0);
    check_val("t6_rst_way1", rd_data_o[2*W-1:W], '0);
    tick();
    rst_n = 1'b1;
    wait_init();
    check_val("t6_init_len", W'(cycles), W'(512));
    rd(9'h040);
    check_val("t6_valid", W'(rd_valid_o), W'(1));
    check_val("t6_clr_040", rd_data_o[2*W-1:W], '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
